// File: rtl/com_intc.sv
// com_intc: fixed-priority interrupt controller on the risc8 8-bit COM bus.
// Define COM_INTC_SYNC_EN to pass every irq_src line through a 2-flop synchronizer.

module com_intc_src (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic clr,
    output logic pend
);
    logic src_s;
    logic prev;
    logic rise;

`ifdef COM_INTC_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (rst) sync <= '0;
        else     sync <= {sync[0], src};
    end

    assign src_s = sync[1];
`else
    assign src_s = src;
`endif

    assign rise = src_s & ~prev;

    // a new edge wins over any clear landing in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
            pend <= 1'b0;
        end else begin
            prev <= src_s;
            pend <= (pend & ~clr) | rise;
        end
    end
endmodule

module com_intc #(
    parameter int          NSRC      = 8,
    parameter logic [7:0]  BASE_ADDR = 8'hF0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      com_addr,
    input  logic [7:0]      com_wr,
    input  logic            com_we,
    output logic [7:0]      com_rd,
    input  logic [NSRC-1:0] irq_src,
    output logic            interrupt
);
    typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

    typedef struct packed {
        logic w1c;
        logic mask_we;
        logic eoi;
        logic ctrl_we;
    } com_acc_t;

    generate
        if (NSRC < 1 || NSRC > 8) begin : g_bad_nsrc
            $error("com_intc: NSRC must be in 1..8");
        end
        if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
            $error("com_intc: BASE_ADDR must be 4-byte aligned");
        end
    endgenerate

    state_t          state, state_nxt;
    com_acc_t        acc;
    logic            sel;
    logic [1:0]      off;
    logic [NSRC-1:0] pending, mask, hit, dclr, clr;
    logic            enable;
    logic [7:0]      vector, vec_nxt, rd_reg;
    logic            dispatch, vec_clr;

    assign sel = (com_addr[7:2] == BASE_ADDR[7:2]);
    assign off = com_addr[1:0];

    always_comb begin
        acc = '0;
        if (com_we && sel) begin
            case (off)
                2'd0: acc.w1c     = 1'b1;
                2'd1: acc.mask_we = 1'b1;
                2'd2: acc.eoi     = 1'b1;
                default: acc.ctrl_we = 1'b1;
            endcase
        end
    end

    assign hit  = pending & mask;
    assign dclr = hit & (~hit + NSRC'(1));
    assign clr  = (acc.w1c ? com_wr[NSRC-1:0] : '0) | (dispatch ? dclr : '0);

    // lowest index wins; vector is 1-based so 0 means nothing in service
    always_comb begin
        vec_nxt = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (hit[i]) vec_nxt = 8'(i + 1);
    end

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        com_intc_src u_src (
            .clk  (clk),
            .rst  (rst),
            .src  (irq_src[g]),
            .clr  (clr[g]),
            .pend (pending[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            interrupt <= 1'b0;
        end else begin
            state     <= state_nxt;
            interrupt <= (state_nxt == ASSERT);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && |hit) state_nxt = ASSERT;
            ASSERT:  state_nxt = SERVICE;
            SERVICE: if (acc.eoi) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dispatch = (state == IDLE) && enable && |hit;
        vec_clr  = (state == SERVICE) && acc.eoi;
    end

    // MASK/CTRL writes land on the same edge as a dispatch decided on the old values
    always_ff @(posedge clk) begin
        if (rst) begin
            mask   <= '0;
            enable <= 1'b0;
            vector <= '0;
        end else begin
            if (acc.mask_we) mask   <= com_wr[NSRC-1:0];
            if (acc.ctrl_we) enable <= com_wr[0];
            if (dispatch)     vector <= vec_nxt;
            else if (vec_clr) vector <= '0;
        end
    end

    always_comb begin
        rd_reg = '0;
        case (off)
            2'd0: rd_reg[NSRC-1:0] = pending;
            2'd1: rd_reg[NSRC-1:0] = mask;
            2'd2: rd_reg           = vector;
            default: rd_reg[0]     = enable;
        endcase
    end

    // the core latches com_rd while interrupt is high, so the vector overrides decode
    assign com_rd = interrupt ? vector : (sel ? rd_reg : 8'h00);
endmodule

// File: tb/tb_com_intc.sv
// tb_com_intc: random + directed stimulus against a behavioural model; a monitor
// pops expected interrupt pulses (cycle, vector) from a scoreboard queue.

module tb_com_intc;
    localparam int         NSRC = 8;
    localparam logic [7:0] BASE = 8'hF0;

    logic            clk;
    logic            rst;
    logic [7:0]      com_addr, com_wr, com_rd;
    logic            com_we;
    logic [NSRC-1:0] irq_src;
    logic            interrupt;

    com_intc #(.NSRC(NSRC), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .com_addr  (com_addr),
        .com_wr    (com_wr),
        .com_we    (com_we),
        .com_rd    (com_rd),
        .irq_src   (irq_src),
        .interrupt (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] vec;
    } pulse_t;

    pulse_t q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model state: plain bit arrays, a busy flag and the cycle of the last dispatch
    logic [7:0]      m_pend = '0, m_mask = '0, m_vec = '0;
    logic            m_en = 1'b0;
    bit              m_busy = 1'b0;
    int              m_disp = -10;
    logic [NSRC-1:0] m_prev = '0, m_s1 = '0, m_s2 = '0, e_in;
    int              first;
    logic [NSRC-1:0] src_v;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_pend = '0; m_mask = '0; m_vec = '0; m_en = 1'b0;
            m_busy = 1'b0; m_prev = '0; m_s1 = '0; m_s2 = '0;
        end else begin
`ifdef COM_INTC_SYNC_EN
            e_in = m_s2; m_s2 = m_s1; m_s1 = irq_src;
`else
            e_in = irq_src;
`endif
            if (!m_busy && m_en && (m_pend & m_mask) != 8'h00) begin
                first = 0;
                while (!(m_pend[first] && m_mask[first])) first++;
                m_pend[first] = 1'b0;
                m_vec  = 8'(first + 1);
                m_busy = 1'b1;
                m_disp = cyc;
                q.push_back('{cyc, m_vec});
            end else if (m_busy && cyc >= m_disp + 2 && com_we && com_addr == BASE + 8'd2) begin
                m_busy = 1'b0;
                m_vec  = 8'h00;
            end
            if (com_we && com_addr == BASE)
                for (int i = 0; i < NSRC; i++) if (com_wr[i]) m_pend[i] = 1'b0;
            for (int i = 0; i < NSRC; i++) if (e_in[i] && !m_prev[i]) m_pend[i] = 1'b1;
            m_prev = e_in;
            if (com_we && com_addr == BASE + 8'd1)
                for (int i = 0; i < NSRC; i++) m_mask[i] = com_wr[i];
            if (com_we && com_addr == BASE + 8'd3) m_en = com_wr[0];
        end
    end

    function automatic logic [7:0] exp_rd(input logic [7:0] a);
        if (m_busy && m_disp == cyc) return m_vec;
        if (a[7:2] != BASE[7:2]) return 8'h00;
        case (a[1:0])
            2'd0:    return m_pend;
            2'd1:    return m_mask;
            2'd2:    return m_vec;
            default: return {7'd0, m_en};
        endcase
    endfunction

    // monitor: every interrupt pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (interrupt === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL pulse: unexpected interrupt cycle=%0d com_rd=%h", cyc, com_rd);
            end else begin
                pulse_t e;
                e = q.pop_front();
                if (e.cyc != cyc || com_rd !== e.vec) begin
                    bad++;
                    $display("FAIL pulse: got cycle=%0d vec=%h expected cycle=%0d vec=%h",
                             cyc, com_rd, e.cyc, e.vec);
                end
            end
        end else if (interrupt !== 1'b0) begin
            total++; bad++;
            $display("FAIL interrupt: got %b expected 0/1 cycle=%0d", interrupt, cyc);
        end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            total++; bad++;
            $display("FAIL pulse: missing interrupt expected cycle=%0d vec=%h", q[0].cyc, q[0].vec);
            void'(q.pop_front());
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h addr=%h cycle=%0d", nm, act, exp, com_addr, cyc);
        end
    endtask

    task automatic step(input logic r, input logic we, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk); #1;
        rst = r; com_we = we; com_addr = a; com_wr = d; irq_src = src_v;
        #1;
        chk("com_rd", com_rd, exp_rd(a));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, BASE + 8'($urandom_range(0, 3)), 8'h00);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        step(1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b0, 1'b0, a, 8'h00);
    endtask

    initial begin
        logic [7:0] a, d;
        logic       r, we;
        int         op;
        rst = 1'b1; com_we = 1'b0; com_addr = 8'h00; com_wr = 8'h00;
        irq_src = '0; src_v = '0;

        // reset then register access
        step(1'b1, 1'b0, BASE, 8'h00);
        step(1'b1, 1'b0, BASE + 8'd2, 8'h00);
        wr(BASE + 8'd1, 8'h0F); wr(BASE + 8'd3, 8'h01);
        rd(BASE + 8'd1); rd(BASE + 8'd3); rd(BASE); rd(BASE + 8'd2); rd(8'h10);

        // single source dispatch and EOI
        wr(BASE + 8'd1, 8'hFF); idle(2);
        src_v[3] = 1'b1; idle(1); rd(BASE + 8'd2); rd(BASE + 8'd2); rd(BASE);
        wr(BASE + 8'd2, 8'h00); rd(BASE + 8'd2);

        // priority and queueing
        src_v = '0; idle(2);
        src_v[5] = 1'b1; src_v[1] = 1'b1; idle(3); rd(BASE);
        wr(BASE + 8'd2, 8'h00); idle(3); rd(BASE + 8'd2); wr(BASE + 8'd2, 8'h00);

        // masked pending, unmask, and W1C before unmask
        src_v = '0; wr(BASE + 8'd1, 8'h00); idle(2);
        src_v[0] = 1'b1; idle(3); rd(BASE);
        wr(BASE + 8'd1, 8'h01); idle(3); wr(BASE + 8'd2, 8'h00);
        wr(BASE + 8'd1, 8'h00); src_v = '0; idle(2);
        src_v[0] = 1'b1; idle(2); wr(BASE, 8'h01); wr(BASE + 8'd1, 8'h01); idle(3); rd(BASE);

        // set beats W1C while busy
        src_v = '0; wr(BASE + 8'd1, 8'hFF); idle(2);
        src_v[6] = 1'b1; idle(3);
        src_v[2] = 1'b1; wr(BASE, 8'h04); idle(3); rd(BASE);
        wr(BASE + 8'd2, 8'h00); idle(3); rd(BASE + 8'd2); wr(BASE + 8'd2, 8'h00);

        // reset mid-service with pending 81
        src_v = '0; idle(2);
        src_v[1] = 1'b1; idle(3);
        src_v[0] = 1'b1; src_v[7] = 1'b1; idle(2); rd(BASE);
        step(1'b1, 1'b0, BASE, 8'h00);
        rd(BASE); rd(BASE + 8'd2); rd(BASE + 8'd1);
        src_v = '0; idle(2);

        // random traffic
        wr(BASE + 8'd3, 8'h01);
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 5) == 0) src_v ^= NSRC'($urandom);
            op = $urandom_range(0, 15);
            a  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, 3));
            d  = 8'($urandom);
            we = 1'b1;
            case (op)
                0, 1:    a = BASE + 8'd1;
                2:       begin a = BASE + 8'd3; if ($urandom_range(0, 3) != 0) d[0] = 1'b1; end
                3:       a = BASE;
                4, 5, 6: a = BASE + 8'd2;
                default: we = 1'b0;
            endcase
            r = ($urandom_range(0, 299) == 0);
            step(r, we, a, d);
        end
        idle(6);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d outstanding pulses expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
